// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard receiver and scan-code decoder producing ASCII plus cursor pulses.
// Optional build macro REPEAT_SUPPRESS_EN: suppress typematic repeats of the held key.
module ps2_key_decoder #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ascii,
    output logic       add_flag,
    output logic       enter_flag,
    output logic       shift,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   bit_in;

    logic [1:0]    state;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          parity_ok;
    logic [TW-1:0] tcnt;
    logic          timeout_hit;
    logic          byte_ok;
    logic          frame_bad;

    logic          brk;
    logic          ext;
    logic [9:0]    map;
    logic          is_shift;
    logic          is_enter;
    logic          mapped;
    logic [7:0]    key_char;
    logic          suppress;

    // Sync flops reset to the idle-high line level so reset never fakes a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign bit_in = dat_sync[SYNC_STAGES-1];

    assign timeout_hit = (state != S_IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign byte_ok     = fall && (state == S_STOP) && bit_in && parity_ok;
    assign frame_bad   = (fall && (state == S_IDLE) && bit_in)
                       || (fall && (state == S_STOP) && !(bit_in && parity_ok))
                       || timeout_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
            parity_ok <= 1'b0;
            tcnt      <= '0;
        end else begin
            if (fall || state == S_IDLE) tcnt <= '0;
            else                         tcnt <= tcnt + 1'b1;

            if (timeout_hit) begin
                state <= S_IDLE;
                tcnt  <= '0;
            end else if (fall) begin
                case (state)
                    S_IDLE: begin
                        if (!bit_in) state <= S_DATA;
                        bitcnt <= '0;
                    end
                    S_DATA: begin
                        shreg  <= {bit_in, shreg[7:1]};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'd7) state <= S_PARITY;
                    end
                    // Parity result is held so a bad parity and the stop bit give one error pulse.
                    S_PARITY: begin
                        parity_ok <= ^{shreg, bit_in};
                        state     <= S_STOP;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Returns {mapped, is_letter, lowercase/ASCII char}.
    function automatic logic [9:0] map_key(input logic [7:0] code);
        logic [9:0] r;
        case (code)
            8'h1C: r = {2'b11, 8'h61}; 8'h32: r = {2'b11, 8'h62};
            8'h21: r = {2'b11, 8'h63}; 8'h23: r = {2'b11, 8'h64};
            8'h24: r = {2'b11, 8'h65}; 8'h2B: r = {2'b11, 8'h66};
            8'h34: r = {2'b11, 8'h67}; 8'h33: r = {2'b11, 8'h68};
            8'h43: r = {2'b11, 8'h69}; 8'h3B: r = {2'b11, 8'h6A};
            8'h42: r = {2'b11, 8'h6B}; 8'h4B: r = {2'b11, 8'h6C};
            8'h3A: r = {2'b11, 8'h6D}; 8'h31: r = {2'b11, 8'h6E};
            8'h44: r = {2'b11, 8'h6F}; 8'h4D: r = {2'b11, 8'h70};
            8'h15: r = {2'b11, 8'h71}; 8'h2D: r = {2'b11, 8'h72};
            8'h1B: r = {2'b11, 8'h73}; 8'h2C: r = {2'b11, 8'h74};
            8'h3C: r = {2'b11, 8'h75}; 8'h2A: r = {2'b11, 8'h76};
            8'h1D: r = {2'b11, 8'h77}; 8'h22: r = {2'b11, 8'h78};
            8'h35: r = {2'b11, 8'h79}; 8'h1A: r = {2'b11, 8'h7A};
            8'h45: r = {2'b10, 8'h30}; 8'h16: r = {2'b10, 8'h31};
            8'h1E: r = {2'b10, 8'h32}; 8'h26: r = {2'b10, 8'h33};
            8'h25: r = {2'b10, 8'h34}; 8'h2E: r = {2'b10, 8'h35};
            8'h36: r = {2'b10, 8'h36}; 8'h3D: r = {2'b10, 8'h37};
            8'h3E: r = {2'b10, 8'h38}; 8'h46: r = {2'b10, 8'h39};
            8'h29: r = {2'b10, 8'h20};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        map      = map_key(shreg);
        is_shift = !ext && (shreg == 8'h12 || shreg == 8'h59);
        is_enter = (shreg == 8'h5A);
        mapped   = is_enter || (!ext && map[9]);
        key_char = map[7:0];
        if (is_enter)           key_char = 8'h0D;
        else if (map[8] && shift) key_char = map[7:0] - 8'h20;
    end

`ifdef REPEAT_SUPPRESS_EN
    logic [8:0] held;
    logic       held_vld;

    always_comb suppress = held_vld && (held == {ext, shreg});

    always_ff @(posedge clk) begin
        if (rst) begin
            held     <= '0;
            held_vld <= 1'b0;
        end else if (byte_ok && shreg != 8'hF0 && shreg != 8'hE0 && !is_shift) begin
            if (!brk) begin
                held     <= {ext, shreg};
                held_vld <= 1'b1;
            end else if (held == {ext, shreg}) begin
                held_vld <= 1'b0;
            end
        end
    end
`else
    always_comb suppress = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ascii      <= '0;
            add_flag   <= 1'b0;
            enter_flag <= 1'b0;
            shift      <= 1'b0;
            frame_err  <= 1'b0;
            brk        <= 1'b0;
            ext        <= 1'b0;
        end else begin
            add_flag   <= 1'b0;
            enter_flag <= 1'b0;
            frame_err  <= frame_bad;
            if (frame_bad) begin
                brk <= 1'b0;
                ext <= 1'b0;
            end else if (byte_ok) begin
                if (shreg == 8'hF0) begin
                    brk <= 1'b1;
                end else if (shreg == 8'hE0) begin
                    ext <= 1'b1;
                end else begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                    if (is_shift) begin
                        shift <= ~brk;
                    end else if (!brk && mapped && !suppress) begin
                        ascii      <= key_char;
                        add_flag   <= 1'b1;
                        enter_flag <= is_enter;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed table-driven bench for ps2_key_decoder; PS/2 frames are bit-banged from tasks.
module tb_ps2_key_decoder;

    localparam int TO = 300;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] ascii;
    logic       add_flag;
    logic       enter_flag;
    logic       shift;
    logic       frame_err;

    ps2_key_decoder #(.SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ascii      (ascii),
        .add_flag   (add_flag),
        .enter_flag (enter_flag),
        .shift      (shift),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;
    int n_add = 0, n_enter = 0, n_ferr = 0;
    int wide_err = 0, enter_alone = 0;
    logic add_q = 1'b0, ferr_q = 1'b0;

    always @(negedge clk) begin
        if (add_flag) n_add++;
        if (enter_flag) n_enter++;
        if (frame_err) n_ferr++;
        if ((add_flag && add_q) || (frame_err && ferr_q)) wide_err++;
        if (enter_flag && !add_flag) enter_alone++;
        add_q  <= add_flag;
        ferr_q <= frame_err;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic d);
        repeat (5) @(negedge clk);
        ps2_data = d;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~(^b) ^ bad_par);
        ps2_bit(1'b1);
        repeat (10) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] code;
        logic [7:0] exp_ascii;
        int         exp_add;
        int         exp_enter;
        logic       exp_shift;
    } vec_t;

    vec_t vecs[24];
    int a0, e0, f0, n, rep_exp;

    initial begin
        vecs[0]  = '{8'h1C, 8'h61, 1, 0, 1'b0};
        vecs[1]  = '{8'h12, 8'h61, 0, 0, 1'b1};
        vecs[2]  = '{8'h1C, 8'h41, 1, 0, 1'b1};
        vecs[3]  = '{8'hF0, 8'h41, 0, 0, 1'b1};
        vecs[4]  = '{8'h1C, 8'h41, 0, 0, 1'b1};
        vecs[5]  = '{8'hF0, 8'h41, 0, 0, 1'b1};
        vecs[6]  = '{8'h12, 8'h41, 0, 0, 1'b0};
        vecs[7]  = '{8'h5A, 8'h0D, 1, 1, 1'b0};
        vecs[8]  = '{8'hE0, 8'h0D, 0, 0, 1'b0};
        vecs[9]  = '{8'h5A, 8'h0D, 1, 1, 1'b0};
        vecs[10] = '{8'h32, 8'h62, 1, 0, 1'b0};
        vecs[11] = '{8'h45, 8'h30, 1, 0, 1'b0};
        vecs[12] = '{8'h29, 8'h20, 1, 0, 1'b0};
        vecs[13] = '{8'h59, 8'h20, 0, 0, 1'b1};
        vecs[14] = '{8'h15, 8'h51, 1, 0, 1'b1};
        vecs[15] = '{8'h46, 8'h39, 1, 0, 1'b1};
        vecs[16] = '{8'h29, 8'h20, 1, 0, 1'b1};
        vecs[17] = '{8'hF0, 8'h20, 0, 0, 1'b1};
        vecs[18] = '{8'h59, 8'h20, 0, 0, 1'b0};
        vecs[19] = '{8'h1A, 8'h7A, 1, 0, 1'b0};
        vecs[20] = '{8'hE0, 8'h7A, 0, 0, 1'b0};
        vecs[21] = '{8'h1C, 8'h7A, 0, 0, 1'b0};
        vecs[22] = '{8'h07, 8'h7A, 0, 0, 1'b0};
        vecs[23] = '{8'h2C, 8'h74, 1, 0, 1'b0};

        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_outputs", {ascii, add_flag, enter_flag, shift, frame_err}, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_no_err", n_ferr, 0);

        foreach (vecs[i]) begin
            a0 = n_add; e0 = n_enter; f0 = n_ferr;
            send(vecs[i].code, 1'b0);
            chk($sformatf("v%0d_ascii", i), ascii, vecs[i].exp_ascii);
            chk($sformatf("v%0d_add", i), n_add - a0, vecs[i].exp_add);
            chk($sformatf("v%0d_enter", i), n_enter - e0, vecs[i].exp_enter);
            chk($sformatf("v%0d_shift", i), shift, vecs[i].exp_shift);
            chk($sformatf("v%0d_ferr", i), n_ferr - f0, 0);
        end

        // Bad parity: one error pulse, key dropped.
        a0 = n_add; f0 = n_ferr;
        send(8'h1C, 1'b1);
        chk("par_ferr", n_ferr - f0, 1);
        chk("par_add", n_add - a0, 0);
        chk("par_ascii", ascii, 8'h74);

        // Timeout after 4 data bits, measured from the drive of the last falling edge.
        f0 = n_ferr;
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        repeat (5) @(negedge clk);
        ps2_data = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        n = 0;
        while (n < TO + 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (frame_err) break;
        end
        chk("timeout_latency", n, TO + SS + 1);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
        chk("timeout_ferr_count", n_ferr - f0, 1);
        a0 = n_add;
        send(8'h29, 1'b0);
        chk("after_to_ascii", ascii, 8'h20);
        chk("after_to_add", n_add - a0, 1);

        // Typematic repeats with a break in between.
`ifdef REPEAT_SUPPRESS_EN
        rep_exp = 2;
`else
        rep_exp = 4;
`endif
        a0 = n_add;
        send(8'h1C, 1'b0); send(8'h1C, 1'b0); send(8'h1C, 1'b0);
        send(8'hF0, 1'b0); send(8'h1C, 1'b0);
        send(8'h1C, 1'b0);
        chk("repeat_pulses", n_add - a0, rep_exp);
        chk("repeat_ascii", ascii, 8'h61);

        // Reset mid-frame with shift held.
        send(8'h12, 1'b0);
        chk("pre_rst_shift", shift, 1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_outputs", {ascii, add_flag, enter_flag, shift, frame_err}, 0);
        rst = 1'b0;
        f0 = n_ferr; a0 = n_add;
        repeat (20) @(negedge clk);
        send(8'h1C, 1'b0);
        chk("post_rst_ascii", ascii, 8'h61);
        chk("post_rst_add", n_add - a0, 1);
        chk("post_rst_ferr", n_ferr - f0, 0);

        chk("pulse_width", wide_err, 0);
        chk("enter_without_add", enter_alone, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
